// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the common-data-bus arbiter slice.
// Port indices name the fixed producer assignment on the CDB.
package cdb_arbiter_pkg;

  localparam int ROB_ID_WIDTH  = 5;
  localparam int CDB_PORT_ALU  = 0;
  localparam int CDB_PORT_LSB  = 1;
  localparam int CDB_NUM_PORTS = 2;

  typedef logic [1:0] fifo_cnt_t;

  localparam fifo_cnt_t FIFO_DEPTH = 2'd2;

  // Modulo-n wrap for an index that is at most 2n-1.
  function automatic int wrap_port(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/cdb_port_fifo.sv
// Two-entry result buffer for one CDB producer; data visible at head one edge after push.
// Push is ignored when full (no same-cycle bypass); flush empties it and wins over push/pop.
module cdb_port_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat,
  output fifo_cnt_t    o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  fifo_cnt_t    r_count;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_do_push = i_push && (r_count != FIFO_DEPTH) && !i_flush;
  assign w_do_pop  = i_pop && (r_count != '0) && !i_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: it is only read while the count is non-zero.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_dat;
  end

  assign o_dat   = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin drain of per-producer result buffers onto a registered CDB; push-to-broadcast is two edges.
// The CDB never stalls; producers see req_ready low only while their own buffer holds two entries.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int N_REQ  = CDB_NUM_PORTS,
  parameter  int ID_W   = ROB_ID_WIDTH,
  parameter  int DATA_W = 32,
  localparam int SRC_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*ID_W-1:0]   req_rob_id,
  input  logic [N_REQ*DATA_W-1:0] req_value,
  input  logic [N_REQ*DATA_W-1:0] req_target,
  input  logic [N_REQ-1:0]    req_taken,
  output logic                cdb_valid,
  output logic [ID_W-1:0]     cdb_rob_id,
  output logic [DATA_W-1:0]   cdb_value,
  output logic [DATA_W-1:0]   cdb_target,
  output logic                cdb_taken,
  output logic [SRC_W-1:0]    cdb_src
);

  localparam int PL_W = ID_W + 2 * DATA_W + 1;

  logic [PL_W-1:0]  w_push_dat [N_REQ];
  logic [PL_W-1:0]  w_head     [N_REQ];
  fifo_cnt_t        w_count    [N_REQ];
  logic [N_REQ-1:0] w_cand;
  logic [N_REQ-1:0] w_pop;
  logic             w_any;
  logic [SRC_W-1:0] w_grant;
  logic [SRC_W-1:0] w_idx;
  logic [SRC_W-1:0] w_rr_next;

  logic              r_cdb_valid;
  logic [ID_W-1:0]   r_cdb_rob_id;
  logic [DATA_W-1:0] r_cdb_value;
  logic [DATA_W-1:0] r_cdb_target;
  logic              r_cdb_taken;
  logic [SRC_W-1:0]  r_cdb_src;
  logic [SRC_W-1:0]  r_rr_ptr;

  for (genvar g = 0; g < N_REQ; g++) begin : g_port
    assign w_push_dat[g] = {req_rob_id[g*ID_W +: ID_W], req_value[g*DATA_W +: DATA_W],
                            req_target[g*DATA_W +: DATA_W], req_taken[g]};

    cdb_port_fifo #(.W(PL_W)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_push  (req_valid[g]),
      .i_pop   (w_pop[g]),
      .i_dat   (w_push_dat[g]),
      .o_dat   (w_head[g]),
      .o_count (w_count[g])
    );

    assign req_ready[g] = (w_count[g] != FIFO_DEPTH);
    assign w_cand[g]    = (w_count[g] != '0);
    assign w_pop[g]     = w_any && (w_grant == SRC_W'(g));
  end

  // First non-empty port at or above the round-robin pointer, wrapping.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = SRC_W'(wrap_port(int'(r_rr_ptr) + k, N_REQ));
      if (!w_any && w_cand[w_idx]) begin
        w_any   = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  assign w_rr_next = SRC_W'(wrap_port(int'(w_grant) + 1, N_REQ));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cdb_valid  <= 1'b0;
      r_cdb_rob_id <= '0;
      r_cdb_value  <= '0;
      r_cdb_target <= '0;
      r_cdb_taken  <= 1'b0;
      r_cdb_src    <= '0;
      r_rr_ptr     <= '0;
    end else if (flush) begin
      r_cdb_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else if (w_any) begin
      r_cdb_valid <= 1'b1;
      {r_cdb_rob_id, r_cdb_value, r_cdb_target, r_cdb_taken} <= w_head[w_grant];
      r_cdb_src   <= w_grant;
      r_rr_ptr    <= w_rr_next;
    end else begin
      r_cdb_valid <= 1'b0;
    end
  end

  assign cdb_valid  = r_cdb_valid;
  assign cdb_rob_id = r_cdb_rob_id;
  assign cdb_value  = r_cdb_value;
  assign cdb_target = r_cdb_target;
  assign cdb_taken  = r_cdb_taken;
  assign cdb_src    = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, hand-built flush/reset/branch sequences,
// and random traffic checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NP   = 2;
  localparam int ID_W = ROB_ID_WIDTH;
  localparam int DW   = 32;

  typedef struct packed {
    logic [ID_W-1:0] rob;
    logic [DW-1:0]   val;
    logic [DW-1:0]   tgt;
    logic            tk;
  } ent_t;

  typedef struct packed {
    logic            fl;
    logic [1:0]      v;
    logic [ID_W-1:0] t0;
    logic [ID_W-1:0] t1;
    logic            e_vld;
    logic [ID_W-1:0] e_tag;
    logic            e_src;
    logic [1:0]      e_rdy;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [NP-1:0]     req_valid;
  logic [NP-1:0]     req_ready;
  logic [NP*ID_W-1:0] req_rob_id;
  logic [NP*DW-1:0]  req_value;
  logic [NP*DW-1:0]  req_target;
  logic [NP-1:0]     req_taken;
  logic              cdb_valid;
  logic [ID_W-1:0]   cdb_rob_id;
  logic [DW-1:0]     cdb_value;
  logic [DW-1:0]     cdb_target;
  logic              cdb_taken;
  logic [0:0]        cdb_src;

  cdb_arbiter #(.N_REQ(NP), .ID_W(ID_W), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rob_id (req_rob_id),
    .req_value  (req_value),
    .req_target (req_target),
    .req_taken  (req_taken),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value),
    .cdb_target (cdb_target),
    .cdb_taken  (cdb_taken),
    .cdb_src    (cdb_src)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one queue per port plus the visible bus state.
  ent_t mq [NP][$];
  int   m_rr;
  logic m_vld;
  ent_t m_pay;
  int   m_src;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [ID_W-1:0] t);
    ent_t e;
    e.rob = t;
    e.val = 32'hA000_0000 | 32'(t);
    e.tgt = 32'hB000_0000 | 32'(t);
    e.tk  = t[0];
    return e;
  endfunction

  function automatic vec_t mkv(input logic fl, input logic [1:0] v, input int t0, input int t1,
                               input logic e_vld, input int e_tag, input logic e_src,
                               input logic [1:0] e_rdy);
    vec_t r;
    r.fl = fl; r.v = v; r.t0 = ID_W'(t0); r.t1 = ID_W'(t1);
    r.e_vld = e_vld; r.e_tag = ID_W'(e_tag); r.e_src = e_src; r.e_rdy = e_rdy;
    return r;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) mq[p].delete();
    m_rr  = 0;
    m_vld = 1'b0;
    m_pay = '0;
    m_src = 0;
  endtask

  task automatic check_bus(input string tag);
    chk({tag, "_valid"},  64'(cdb_valid),  64'(m_vld));
    chk({tag, "_rob_id"}, 64'(cdb_rob_id), 64'(m_pay.rob));
    chk({tag, "_value"},  64'(cdb_value),  64'(m_pay.val));
    chk({tag, "_target"}, 64'(cdb_target), 64'(m_pay.tgt));
    chk({tag, "_taken"},  64'(cdb_taken),  64'(m_pay.tk));
    chk({tag, "_src"},    64'(cdb_src),    64'(m_src));
  endtask

  // Drive one cycle of inputs, advance the model, then check the bus after the edge.
  task automatic cyc(input logic fl, input logic [NP-1:0] v, input ent_t e0, input ent_t e1);
    logic [NP-1:0] rdy_pre;
    ent_t ein [NP];
    int   g;
    bit   found;
    ein[0] = e0;
    ein[1] = e1;
    flush      = fl;
    req_valid  = v;
    req_rob_id = {e1.rob, e0.rob};
    req_value  = {e1.val, e0.val};
    req_target = {e1.tgt, e0.tgt};
    req_taken  = {e1.tk, e0.tk};
    for (int p = 0; p < NP; p++) rdy_pre[p] = (mq[p].size() < 2);
    chk("req_ready", 64'(req_ready), 64'(rdy_pre));
    if (fl) begin
      for (int p = 0; p < NP; p++) mq[p].delete();
      m_vld = 1'b0;
      m_rr  = 0;
    end else begin
      found = 0;
      g     = 0;
      for (int k = 0; k < NP; k++) begin
        if (!found && mq[(m_rr + k) % NP].size() != 0) begin
          found = 1;
          g     = (m_rr + k) % NP;
        end
      end
      if (found) begin
        m_pay = mq[g].pop_front();
        m_vld = 1'b1;
        m_src = g;
        m_rr  = (g + 1) % NP;
      end else begin
        m_vld = 1'b0;
      end
      for (int p = 0; p < NP; p++)
        if (v[p] && rdy_pre[p]) mq[p].push_back(ein[p]);
    end
    @(posedge clk);
    #1;
    check_bus("cdb");
  endtask

  initial begin
    ent_t br;
    ent_t r0;
    ent_t r1;
    logic [NP-1:0] rv;

    rst = 1'b1; flush = 1'b0; req_valid = '0;
    req_rob_id = '0; req_value = '0; req_target = '0; req_taken = '0;
    model_reset();

    tbl[0]  = mkv(1'b0, 2'b01, 3, 0, 1'b0, 0, 1'b0, 2'b11);
    tbl[1]  = mkv(1'b0, 2'b01, 4, 0, 1'b1, 3, 1'b0, 2'b11);
    tbl[2]  = mkv(1'b0, 2'b01, 5, 0, 1'b1, 4, 1'b0, 2'b11);
    tbl[3]  = mkv(1'b0, 2'b00, 0, 0, 1'b1, 5, 1'b0, 2'b11);
    tbl[4]  = mkv(1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 2'b11);
    tbl[5]  = mkv(1'b1, 2'b00, 0, 0, 1'b0, 0, 1'b0, 2'b11);
    tbl[6]  = mkv(1'b0, 2'b11, 1, 8, 1'b0, 0, 1'b0, 2'b11);
    tbl[7]  = mkv(1'b0, 2'b11, 2, 9, 1'b1, 1, 1'b0, 2'b01);
    tbl[8]  = mkv(1'b0, 2'b00, 0, 0, 1'b1, 8, 1'b1, 2'b11);
    tbl[9]  = mkv(1'b0, 2'b00, 0, 0, 1'b1, 2, 1'b0, 2'b11);
    tbl[10] = mkv(1'b0, 2'b00, 0, 0, 1'b1, 9, 1'b1, 2'b11);
    tbl[11] = mkv(1'b0, 2'b00, 0, 0, 1'b0, 0, 1'b0, 2'b11);

    @(posedge clk);
    #1;
    check_bus("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("release_ready", 64'(req_ready), 64'd3);
    chk("release_valid", 64'(cdb_valid), 64'd0);

    // Single-port streaming, flush, then two-port contention.
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].fl, tbl[i].v, mk(tbl[i].t0), mk(tbl[i].t1));
      chk($sformatf("vec%0d_valid", i), 64'(cdb_valid), 64'(tbl[i].e_vld));
      if (tbl[i].e_vld) begin
        chk($sformatf("vec%0d_tag", i), 64'(cdb_rob_id), 64'(tbl[i].e_tag));
        chk($sformatf("vec%0d_src", i), 64'(cdb_src), 64'(tbl[i].e_src));
      end
      chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(tbl[i].e_rdy));
    end

    // Flush with ALU 1 + LSB 2 pending and new pushes offered; rr pointer was at port 1.
    cyc(1'b0, 2'b11, mk(20), mk(24));
    cyc(1'b0, 2'b11, mk(21), mk(25));
    chk("preflush_tag", 64'(cdb_rob_id), 64'd20);
    chk("preflush_ready", 64'(req_ready), 64'd1);
    cyc(1'b1, 2'b11, mk(26), mk(27));
    chk("flush_valid", 64'(cdb_valid), 64'd0);
    chk("flush_ready", 64'(req_ready), 64'd3);
    cyc(1'b0, 2'b11, mk(29), mk(28));
    chk("postflush_idle", 64'(cdb_valid), 64'd0);
    cyc(1'b0, 2'b00, '0, '0);
    chk("postflush_first_tag", 64'(cdb_rob_id), 64'd29);
    chk("postflush_first_src", 64'(cdb_src), 64'(CDB_PORT_ALU));
    cyc(1'b0, 2'b00, '0, '0);
    chk("postflush_second_tag", 64'(cdb_rob_id), 64'd28);
    chk("postflush_second_src", 64'(cdb_src), 64'(CDB_PORT_LSB));
    cyc(1'b0, 2'b00, '0, '0);
    chk("postflush_drained", 64'(cdb_valid), 64'd0);

    // Branch payload passes through untouched.
    br.rob = ID_W'(6); br.val = 32'h0000_1004; br.tgt = 32'h0000_2000; br.tk = 1'b1;
    cyc(1'b0, 2'b01, br, '0);
    cyc(1'b0, 2'b00, '0, '0);
    chk("branch_valid",  64'(cdb_valid),  64'd1);
    chk("branch_rob_id", 64'(cdb_rob_id), 64'd6);
    chk("branch_value",  64'(cdb_value),  64'h1004);
    chk("branch_target", 64'(cdb_target), 64'h2000);
    chk("branch_taken",  64'(cdb_taken),  64'd1);

    // Asynchronous reset mid-stream with entries buffered in both ports.
    cyc(1'b0, 2'b11, mk(11), mk(12));
    cyc(1'b0, 2'b11, mk(13), mk(14));
    chk("prereset_valid", 64'(cdb_valid), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_bus("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rereset_ready", 64'(req_ready), 64'd3);
    chk("rereset_valid", 64'(cdb_valid), 64'd0);
    cyc(1'b0, 2'b00, '0, '0);
    cyc(1'b0, 2'b00, '0, '0);

    // Random traffic: heavy load first (exercises full buffers), lighter load later.
    for (int n = 0; n < 600; n++) begin
      r0.rob = ID_W'($urandom); r0.val = $urandom; r0.tgt = $urandom; r0.tk = 1'($urandom);
      r1.rob = ID_W'($urandom); r1.val = $urandom; r1.tgt = $urandom; r1.tk = 1'($urandom);
      if (n < 300) rv = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b11;
      else         rv = 2'($urandom_range(0, 3));
      cyc(($urandom_range(0, 39) == 0), rv, r0, r1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
